// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_cfg_if : serial line, oversampling tick and frame report bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_rx;
  logic                 i_tick;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_busy;

  modport master (
    output i_rx, i_tick,
    input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_busy
  );

  modport slave (
    input  i_rx, i_tick,
    output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_cfg : parametrised UART receiver, 3-sample majority vote per bit
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input wire           i_clk,
  input wire           i_reset_n,
  uart_rx_cfg_if.slave bus
);
  localparam int c_M   = OVERSAMPLE / 2;
  localparam int c_TCW = $clog2(OVERSAMPLE);
  localparam int c_BCW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  logic                 r_sync1, r_sync2;
  state_t               r_state, w_state_n;
  logic [c_TCW-1:0]     r_tc, w_tc_n, w_tc_inc;
  logic [c_BCW-1:0]     r_bc, w_bc_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_s0, r_s1, w_s0_n, w_s1_n;
  logic                 r_perr_acc, w_perr_acc_n;
  logic                 r_ferr_acc, w_ferr_acc_n;
  logic                 r_zero_acc, w_zero_acc_n;
  logic [DATA_BITS-1:0] r_data, w_data_n;
  logic                 r_valid, w_valid_n;
  logic                 r_perr, w_perr_n;
  logic                 r_ferr, w_ferr_n;
  logic                 r_brk, w_brk_n;

  logic w_rx_s, w_last, w_resolve, w_maj, w_par_x;

  assign w_rx_s    = r_sync2;
  assign w_last    = bus.i_tick && (r_tc == c_TCW'(OVERSAMPLE - 1));
  assign w_resolve = bus.i_tick && (r_tc == c_TCW'(c_M + 1));
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
  assign w_par_x   = ^{r_shift, w_maj};
  assign w_tc_inc  = w_last ? '0 : r_tc + 1'b1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= S_IDLE;
      r_tc       <= '0;
      r_bc       <= '0;
      r_shift    <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_zero_acc <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_sync1    <= bus.i_rx;
      r_sync2    <= r_sync1;
      r_state    <= w_state_n;
      r_tc       <= w_tc_n;
      r_bc       <= w_bc_n;
      r_shift    <= w_shift_n;
      r_s0       <= w_s0_n;
      r_s1       <= w_s1_n;
      r_perr_acc <= w_perr_acc_n;
      r_ferr_acc <= w_ferr_acc_n;
      r_zero_acc <= w_zero_acc_n;
      r_data     <= w_data_n;
      r_valid    <= w_valid_n;
      r_perr     <= w_perr_n;
      r_ferr     <= w_ferr_n;
      r_brk      <= w_brk_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_tc_n       = r_tc;
    w_bc_n       = r_bc;
    w_shift_n    = r_shift;
    w_s0_n       = (bus.i_tick && r_tc == c_TCW'(c_M - 1)) ? w_rx_s : r_s0;
    w_s1_n       = (bus.i_tick && r_tc == c_TCW'(c_M))     ? w_rx_s : r_s1;
    w_perr_acc_n = r_perr_acc;
    w_ferr_acc_n = r_ferr_acc;
    w_zero_acc_n = r_zero_acc;
    w_data_n     = r_data;
    w_valid_n    = 1'b0;
    w_perr_n     = r_perr;
    w_ferr_n     = r_ferr;
    w_brk_n      = r_brk;

    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_n    = S_START;
          w_tc_n       = '0;
          w_perr_acc_n = 1'b0;
          w_ferr_acc_n = 1'b0;
          w_zero_acc_n = 1'b1;
        end
      end
      S_START: begin
        if (bus.i_tick) begin
          w_tc_n = w_tc_inc;
          if (w_resolve && w_maj) begin
            w_state_n = S_IDLE;
            w_tc_n    = '0;
          end else if (w_last) begin
            w_state_n = S_DATA;
            w_bc_n    = '0;
          end
        end
      end
      S_DATA: begin
        if (bus.i_tick) begin
          w_tc_n = w_tc_inc;
          if (w_resolve) begin
            w_shift_n    = {w_maj, r_shift[DATA_BITS-1:1]};
            w_zero_acc_n = r_zero_acc & ~w_maj;
          end
          if (w_last) begin
            if (r_bc == c_BCW'(DATA_BITS - 1)) begin
              w_bc_n    = '0;
              w_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              w_bc_n = r_bc + 1'b1;
            end
          end
        end
      end
      S_PARITY: begin
        if (bus.i_tick) begin
          w_tc_n = w_tc_inc;
          if (w_resolve) begin
            w_perr_acc_n = (PARITY == 1) ? ~w_par_x : w_par_x;
            w_zero_acc_n = r_zero_acc & ~w_maj;
          end
          if (w_last) begin
            w_state_n = S_STOP;
            w_bc_n    = '0;
          end
        end
      end
      S_STOP: begin
        if (bus.i_tick) begin
          w_tc_n = w_tc_inc;
          if (w_resolve) begin
            w_ferr_acc_n = r_ferr_acc | ~w_maj;
            w_zero_acc_n = r_zero_acc & ~w_maj;
            // Last stop bit completes at mid-bit so the next start edge is not missed
            if (r_bc == c_BCW'(STOP_BITS - 1)) begin
              w_valid_n = 1'b1;
              w_data_n  = r_shift;
              w_perr_n  = r_perr_acc;
              w_ferr_n  = r_ferr_acc | ~w_maj;
              w_brk_n   = r_zero_acc & ~w_maj;
              w_tc_n    = '0;
              w_state_n = (r_zero_acc & ~w_maj) ? S_WAIT_HIGH : S_IDLE;
            end
          end else if (w_last) begin
            w_bc_n = r_bc + 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign bus.o_data       = r_data;
  assign bus.o_valid      = r_valid;
  assign bus.o_parity_err = r_perr;
  assign bus.o_frame_err  = r_ferr;
  assign bus.o_break      = r_brk;
  assign bus.o_busy       = (r_state != S_IDLE);
endmodule
`default_nettype wire
